// File: rtl/quad_step_gen.sv
// Quadrature A/B phase generator: turns a (direction, step count, period)
// command into a Gray-coded phase stream and tracks the dial position mod 2^CNT_W.
module quad_step_gen #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             DIR,
  input  logic [CNT_W-1:0] STEPS,
  input  logic [DIV_W-1:0] PERIOD,
  input  logic             POS_LD,
  input  logic [CNT_W-1:0] POS_IN,
  output logic             PH_A,
  output logic             PH_B,
  output logic             BUSY,
  output logic             DONE,
  output logic             STEP_STB,
  output logic [CNT_W-1:0] POS
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_n;
  logic             dir_q, dir_n;
  logic [DIV_W-1:0] reload_q, reload_n;
  logic [DIV_W-1:0] div_q, div_n;
  logic [CNT_W-1:0] remain_q, remain_n;
  logic [1:0]       ph_q, ph_n;
  logic [CNT_W-1:0] pos_q, pos_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic             stb_q, stb_n;
  logic [1:0]       ph_step;

  // One Gray step of {A,B}: right walks 00->10->11->01, left walks it backwards.
  always_comb begin
    ph_step = ph_q;
    unique case ({dir_q, ph_q})
      3'b1_00: ph_step = 2'b10;
      3'b1_10: ph_step = 2'b11;
      3'b1_11: ph_step = 2'b01;
      3'b1_01: ph_step = 2'b00;
      3'b0_00: ph_step = 2'b01;
      3'b0_01: ph_step = 2'b11;
      3'b0_11: ph_step = 2'b10;
      3'b0_10: ph_step = 2'b00;
      default: ph_step = ph_q;
    endcase
  end

  always_comb begin
    state_n  = state;
    dir_n    = dir_q;
    reload_n = reload_q;
    div_n    = div_q;
    remain_n = remain_q;
    ph_n     = ph_q;
    pos_n    = pos_q;
    busy_n   = busy_q;
    done_n   = 1'b0;
    stb_n    = 1'b0;

    unique case (state)
      IDLE: begin
        if (POS_LD) begin
          pos_n = POS_IN;
        end
        if (START) begin
          dir_n    = DIR;
          remain_n = STEPS;
          // A zero period runs at one transition per clock, same as PERIOD=1.
          reload_n = (PERIOD == '0) ? '0 : PERIOD - DIV_ONE;
          div_n    = reload_n;
          busy_n   = 1'b1;
          state_n  = RUN;
        end
      end

      RUN: begin
        if (remain_q == '0) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else if (div_q != '0) begin
          div_n = div_q - DIV_ONE;
        end else begin
          ph_n     = ph_step;
          pos_n    = dir_q ? pos_q + CNT_ONE : pos_q - CNT_ONE;
          remain_n = remain_q - CNT_ONE;
          div_n    = reload_q;
          stb_n    = 1'b1;
          // The last transition finishes the command on the same edge.
          if (remain_q == CNT_ONE) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= IDLE;
      dir_q    <= 1'b0;
      reload_q <= '0;
      div_q    <= '0;
      remain_q <= '0;
      ph_q     <= 2'b00;
      pos_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      stb_q    <= 1'b0;
    end else begin
      state    <= state_n;
      dir_q    <= dir_n;
      reload_q <= reload_n;
      div_q    <= div_n;
      remain_q <= remain_n;
      ph_q     <= ph_n;
      pos_q    <= pos_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
      stb_q    <= stb_n;
    end
  end

  assign PH_A     = ph_q[1];
  assign PH_B     = ph_q[0];
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign STEP_STB = stb_q;
  assign POS      = pos_q;

endmodule

// File: tb/tb_quad_step_gen.sv
// Self-checking bench for quad_step_gen: table of directed commands, hand-written
// reset/loopback sequences, then random commands against a timeline model.
module tb_quad_step_gen;

  logic       CLK = 1'b0;
  logic       RST;
  logic       START;
  logic       DIR;
  logic [4:0] STEPS;
  logic [7:0] PERIOD;
  logic       POS_LD;
  logic [4:0] POS_IN;
  logic       PH_A, PH_B, BUSY, DONE, STEP_STB;
  logic [4:0] POS;

  int compared = 0;
  int mismatched = 0;

  // Bench-side view of the dial: position and a signed count of Gray steps taken.
  int model_pos = 0;
  int model_ps  = 0;

  // Simple quadrature decoder watching the phase lines.
  int   dec_count = 0;
  logic dec_dir = 1'b0;
  logic [1:0] dec_prev = 2'b00;

  typedef struct {
    logic dir;
    int   steps;
    int   period;
    logic ld;
    int   pos_in;
    logic disturb;
    int   exp_pos;
    logic [1:0] exp_ph;
  } cmd_t;

  cmd_t tbl[5];
  logic [1:0] gray_seq[4];

  quad_step_gen #(.DIV_W(8), .CNT_W(5)) dut (
    .CLK(CLK), .RST(RST), .START(START), .DIR(DIR), .STEPS(STEPS),
    .PERIOD(PERIOD), .POS_LD(POS_LD), .POS_IN(POS_IN), .PH_A(PH_A),
    .PH_B(PH_B), .BUSY(BUSY), .DONE(DONE), .STEP_STB(STEP_STB), .POS(POS)
  );

  always #5 CLK = ~CLK;

  function automatic int md(input int v, input int m);
    return ((v % m) + m) % m;
  endfunction

  function automatic int gray_idx(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  always @(negedge CLK) begin
    int d;
    d = md(gray_idx({PH_A, PH_B}) - gray_idx(dec_prev), 4);
    if (d == 1) begin
      dec_count = md(dec_count + 1, 32);
      dec_dir = 1'b1;
    end else if (d == 3) begin
      dec_count = md(dec_count - 1, 32);
      dec_dir = 1'b0;
    end
    dec_prev = {PH_A, PH_B};
  end

  task automatic check_output(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int k, input int ph, input int pos,
                           input int busy, input int done, input int stb);
    check_output($sformatf("%s k=%0d phase", tag, k), {PH_A, PH_B}, ph);
    check_output($sformatf("%s k=%0d pos", tag, k), POS, pos);
    check_output($sformatf("%s k=%0d busy", tag, k), BUSY, busy);
    check_output($sformatf("%s k=%0d done", tag, k), DONE, done);
    check_output($sformatf("%s k=%0d step_stb", tag, k), STEP_STB, stb);
  endtask

  // Drives one command at the current negedge and checks every cycle until idle.
  // Expected outputs follow from the command timeline: transition j lands on edge j*P.
  task automatic apply_stimulus(input cmd_t c, input string tag);
    int p, n, endk, t, sgn;
    p    = (c.period == 0) ? 1 : c.period;
    n    = c.steps;
    endk = (n == 0) ? 1 : n * p;
    sgn  = c.dir ? 1 : -1;
    START  = 1'b1;
    DIR    = c.dir;
    STEPS  = 5'(c.steps);
    PERIOD = 8'(c.period);
    POS_LD = c.ld;
    POS_IN = 5'(c.pos_in);
    if (c.ld) model_pos = c.pos_in;
    for (int k = 0; k <= endk + 1; k++) begin
      @(negedge CLK);
      t = (k / p < n) ? k / p : n;
      check_all(tag, k,
                gray_seq[md(model_ps + sgn * t, 4)],
                md(model_pos + sgn * t, 32),
                (k < endk) ? 1 : 0,
                (k == endk) ? 1 : 0,
                (k > 0 && k % p == 0 && k / p <= n) ? 1 : 0);
      if (k == 0) begin
        START  = 1'b0;
        POS_LD = 1'b0;
        DIR    = ~c.dir;
        STEPS  = 5'($urandom);
        PERIOD = 8'($urandom);
      end
      if (c.disturb && k == 1 && endk >= 3) begin
        START  = 1'b1;
        POS_LD = 1'b1;
        POS_IN = 5'($urandom);
      end
      if (k == 2) begin
        START  = 1'b0;
        POS_LD = 1'b0;
      end
    end
    model_pos = md(model_pos + sgn * n, 32);
    model_ps  = md(model_ps + sgn * n, 4);
  endtask

  initial begin
    cmd_t c;
    gray_seq[0] = 2'b00;
    gray_seq[1] = 2'b10;
    gray_seq[2] = 2'b11;
    gray_seq[3] = 2'b01;

    //            dir   steps per ld    posin dist  exp_pos exp_ph
    tbl[0] = '{1'b1, 4, 3, 1'b0, 0, 1'b0, 4,  2'b00};
    tbl[1] = '{1'b0, 3, 0, 1'b1, 1, 1'b0, 30, 2'b10};
    tbl[2] = '{1'b1, 0, 5, 1'b0, 0, 1'b0, 30, 2'b10};
    tbl[3] = '{1'b1, 5, 2, 1'b0, 0, 1'b1, 3,  2'b11};
    tbl[4] = '{1'b0, 2, 1, 1'b1, 0, 1'b0, 30, 2'b00};

    RST = 1'b0; START = 1'b0; DIR = 1'b0; STEPS = '0; PERIOD = '0;
    POS_LD = 1'b0; POS_IN = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      check_all("idle", k, 2'b00, 0, 0, 0, 0);
    end

    for (int i = 0; i < 5; i++) begin
      apply_stimulus(tbl[i], $sformatf("tbl%0d", i));
      check_output($sformatf("tbl%0d final pos", i), POS, tbl[i].exp_pos);
      check_output($sformatf("tbl%0d final phase", i), {PH_A, PH_B}, tbl[i].exp_ph);
    end

    // Reset after the second transition of an 8-step command.
    START = 1'b1; DIR = 1'b1; STEPS = 5'd8; PERIOD = 8'd2; POS_LD = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      @(negedge CLK);
      START = 1'b0;
      if (k == 4) begin
        check_output("midrst pre pos", POS, md(model_pos + 2, 32));
        check_output("midrst pre busy", BUSY, 1);
      end
    end
    RST = 1'b0;
    @(negedge CLK);
    check_all("midrst", 0, 2'b00, 0, 0, 0, 0);
    RST = 1'b1;
    @(negedge CLK);
    check_all("midrst", 1, 2'b00, 0, 0, 0, 0);
    model_pos = 0;
    model_ps  = 0;
    @(negedge CLK);
    dec_count = 0;

    // Loopback: seven right steps into the decoder.
    c = '{1'b1, 7, 2, 1'b0, 0, 1'b0, 7, 2'b01};
    apply_stimulus(c, "loop");
    check_output("loop pos", POS, 7);
    check_output("loop phase", {PH_A, PH_B}, c.exp_ph);
    check_output("loop dec count", dec_count, 7);
    check_output("loop dec dir", dec_dir, 1);

    for (int i = 0; i < 20; i++) begin
      c.dir     = 1'($urandom);
      c.steps   = int'($urandom_range(0, 9));
      c.period  = int'($urandom_range(0, 4));
      c.ld      = 1'($urandom);
      c.pos_in  = int'($urandom_range(0, 31));
      c.disturb = 1'($urandom);
      apply_stimulus(c, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
